// File: rtl/adma_dm_axi_aw.sv
// rtl/adma_dm_axi_aw.sv - DMA data mover AXI write-address burst issuer
// Optional 4 KB burst splitting is enabled by defining ADMA_DM_AW_4KB_SPLIT_EN.
module adma_dm_axi_aw #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int MST_ID_W       = 5,
  parameter int ADDR_W         = 32,
  parameter int ATX_DST_DATA_W = 256,
  parameter int ATX_MAX_BURST  = 256,
  parameter int BEAT_CNT_W     = 16,
  parameter int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DMA_CHN_NUM_W-1:0]        req_chn_id,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [BEAT_CNT_W-1:0]           req_beats,
  input  logic                            req_vld,
  output logic                            req_rdy,
  output logic                            req_done,
  output logic [DMA_CHN_NUM_W-1:0]        req_done_chn_id,
  input  logic [DMA_CHN_NUM*MST_ID_W-1:0] chn_awid,
  output logic [DMA_CHN_NUM_W-1:0]        atx_chn_id,
  output logic [MST_ID_W-1:0]             atx_awid,
  output logic                            atx_vld,
  input  logic                            atx_rdy,
  output logic [DMA_CHN_NUM_W-1:0]        wtx_chn_id,
  output logic [7:0]                      wtx_len,
  output logic                            wtx_vld,
  input  logic                            wtx_rdy,
  output logic [MST_ID_W-1:0]             m_awid_o,
  output logic [ADDR_W-1:0]               m_awaddr_o,
  output logic [7:0]                      m_awlen_o,
  output logic [2:0]                      m_awsize_o,
  output logic [1:0]                      m_awburst_o,
  output logic                            m_awvalid_o,
  input  logic                            m_awready_i
);

  localparam int BEAT_BYTES = ATX_DST_DATA_W / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [DMA_CHN_NUM_W-1:0] chn;
  logic [ADDR_W-1:0]        addr;
  logic [BEAT_CNT_W-1:0]    rem;
  logic [8:0]               beats;
  logic [8:0]               iss_beats;
  logic [MST_ID_W-1:0]      chn_id_sel;
  logic                     push;
  logic                     req_hs;
  logic                     aw_hs;
  logic                     last_burst;

  assign chn_id_sel = chn_awid[32'(chn)*MST_ID_W +: MST_ID_W];
  // The burst in flight is recovered from AWLEN rather than kept in a second register.
  assign iss_beats  = {1'b0, m_awlen_o} + 9'd1;
  assign last_burst = (rem == BEAT_CNT_W'(iss_beats));

`ifdef ADMA_DM_AW_4KB_SPLIT_EN
  logic [12:0] to4k;
  assign to4k = 13'((13'd4096 - {1'b0, addr[11:0]}) >> BEAT_SHIFT);
`endif

  always_comb begin
    beats = 9'(ATX_MAX_BURST);
    if (32'(rem) < 32'(ATX_MAX_BURST)) beats = 9'(rem);
`ifdef ADMA_DM_AW_4KB_SPLIT_EN
    if (32'(to4k) < 32'(beats)) beats = 9'(to4k);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_rdy     = 1'b0;
    push        = 1'b0;
    m_awvalid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (req_vld && (req_beats != '0)) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (atx_rdy && wtx_rdy) begin
          push      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) state_nxt = last_burst ? ST_IDLE : ST_CALC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_hs     = req_vld & req_rdy;
  assign aw_hs      = m_awvalid_o & m_awready_i;
  assign atx_vld    = push;
  assign wtx_vld    = push;
  assign atx_chn_id = chn;
  assign atx_awid   = chn_id_sel;
  assign wtx_chn_id = chn;
  assign wtx_len    = 8'(beats - 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chn             <= '0;
      addr            <= '0;
      rem             <= '0;
      req_done        <= 1'b0;
      req_done_chn_id <= '0;
      m_awid_o        <= '0;
      m_awaddr_o      <= '0;
      m_awlen_o       <= '0;
      m_awsize_o      <= '0;
      m_awburst_o     <= '0;
    end else begin
      req_done <= 1'b0;
      if (req_hs) begin
        chn  <= req_chn_id;
        addr <= req_addr & ~ADDR_W'(BEAT_BYTES - 1);
        rem  <= req_beats;
        // Zero-beat requests complete without touching the AXI side.
        if (req_beats == '0) begin
          req_done        <= 1'b1;
          req_done_chn_id <= req_chn_id;
        end
      end
      if (push) begin
        m_awaddr_o  <= addr;
        m_awlen_o   <= 8'(beats - 9'd1);
        m_awsize_o  <= 3'(BEAT_SHIFT);
        m_awburst_o <= 2'b01;
        m_awid_o    <= chn_id_sel;
      end
      if (aw_hs) begin
        addr <= addr + (ADDR_W'(iss_beats) << BEAT_SHIFT);
        rem  <= rem - BEAT_CNT_W'(iss_beats);
        if (last_burst) begin
          req_done        <= 1'b1;
          req_done_chn_id <= chn;
        end
      end
    end
  end

endmodule

// File: tb/tb_adma_dm_axi_aw.sv
// tb/tb_adma_dm_axi_aw.sv - self-checking bench for adma_dm_axi_aw
// Burst list per request is derived from address/beat arithmetic; honours ADMA_DM_AW_4KB_SPLIT_EN.
module tb_adma_dm_axi_aw;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [4:0]  id;
    logic [1:0]  chn;
    bit          last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_chn_id = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_beats = '0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_done;
  logic [1:0]  req_done_chn_id;
  logic [19:0] chn_awid = {5'd23, 5'd17, 5'd9, 5'd4};
  logic [1:0]  atx_chn_id;
  logic [4:0]  atx_awid;
  logic        atx_vld;
  logic        atx_rdy = 1'b1;
  logic [1:0]  wtx_chn_id;
  logic [7:0]  wtx_len;
  logic        wtx_vld;
  logic        wtx_rdy = 1'b1;
  logic [4:0]  m_awid_o;
  logic [31:0] m_awaddr_o;
  logic [7:0]  m_awlen_o;
  logic [2:0]  m_awsize_o;
  logic [1:0]  m_awburst_o;
  logic        m_awvalid_o;
  logic        m_awready_i = 1'b1;

  adma_dm_axi_aw dut (
    .clk(clk), .rst_n(rst_n),
    .req_chn_id(req_chn_id), .req_addr(req_addr), .req_beats(req_beats),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_done(req_done), .req_done_chn_id(req_done_chn_id),
    .chn_awid(chn_awid),
    .atx_chn_id(atx_chn_id), .atx_awid(atx_awid), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .wtx_chn_id(wtx_chn_id), .wtx_len(wtx_len), .wtx_vld(wtx_vld), .wtx_rdy(wtx_rdy),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass = 0;
  burst_t aw_q[$];
  burst_t push_q[$];
  burst_t aw_log[$];
  burst_t cb;
  burst_t lb;
  bit     done_due = 0;
  logic [1:0] done_chn = '0;
  int     outstanding = 0;
  int     push_cnt = 0;
  int     done_cnt = 0;
  logic [1:0] last_done_chn = '0;
  bit     rand_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: condition not met (got false, expected true)", name);
  endtask

  // Reference: split a request into INCR bursts from its address and beat count.
  function automatic void model_req(input logic [1:0] c, input logic [31:0] a0, input int nb);
    logic [31:0] a;
    int r;
    int n;
    int to4k;
    burst_t b;
    a = a0 & 32'hFFFF_FFE0;
    r = nb;
    if (nb == 0) begin
      done_due = 1;
      done_chn = c;
      return;
    end
    while (r > 0) begin
      n = (r > 256) ? 256 : r;
`ifdef ADMA_DM_AW_4KB_SPLIT_EN
      to4k = (4096 - int'(a[11:0])) / 32;
      if (n > to4k) n = to4k;
`else
      to4k = 0;
`endif
      b.addr = a;
      b.len  = 8'(n - 1);
      b.id   = 5'(chn_awid >> (5 * int'(c)));
      b.chn  = c;
      r      = r - n;
      b.last = (r == 0);
      aw_q.push_back(b);
      push_q.push_back(b);
      a = a + 32'(n * 32);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_q.delete();
      push_q.delete();
      done_due    = 0;
      outstanding = 0;
    end else begin
      check("req_done", req_done, done_due);
      if (done_due && req_done) check("req_done_chn", req_done_chn_id, done_chn);
      if (req_done) begin
        done_cnt++;
        last_done_chn = req_done_chn_id;
      end
      done_due = 0;
      check("req_rdy", req_rdy, aw_q.size() == 0);
      check("wtx_vld_vs_atx_vld", wtx_vld, atx_vld);
      if (atx_vld) begin
        check("push_ahead_of_aw", outstanding, 0);
        check("push_when_ready", atx_rdy & wtx_rdy, 1);
        if (push_q.size() == 0) fail("push_unexpected");
        else begin
          cb = push_q.pop_front();
          check("atx_chn_id", atx_chn_id, cb.chn);
          check("wtx_chn_id", wtx_chn_id, cb.chn);
          check("atx_awid", atx_awid, cb.id);
          check("wtx_len", wtx_len, cb.len);
          outstanding++;
          push_cnt++;
        end
      end
      if (m_awvalid_o) begin
        check("aw_after_push", outstanding, 1);
        if (aw_q.size() == 0) fail("aw_unexpected");
        else begin
          cb = aw_q[0];
          check("awaddr", m_awaddr_o, cb.addr);
          check("awlen", m_awlen_o, cb.len);
          check("awid", m_awid_o, cb.id);
          check("awsize", m_awsize_o, 3'd5);
          check("awburst", m_awburst_o, 2'b01);
          if (m_awready_i) begin
            void'(aw_q.pop_front());
            outstanding--;
            lb.addr = m_awaddr_o;
            lb.len  = m_awlen_o;
            lb.id   = m_awid_o;
            lb.chn  = cb.chn;
            lb.last = cb.last;
            aw_log.push_back(lb);
            if (cb.last) begin
              done_due = 1;
              done_chn = cb.chn;
            end
          end
        end
      end
      if (req_vld && req_rdy) model_req(req_chn_id, req_addr, int'(req_beats));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      atx_rdy     = ($urandom_range(0, 3) != 0);
      wtx_rdy     = ($urandom_range(0, 3) != 0);
      m_awready_i = ($urandom_range(0, 1) != 0);
    end
  end

  task automatic send_req(input logic [1:0] c, input logic [31:0] a, input int nb);
    int k;
    @(posedge clk);
    #1;
    req_chn_id = c;
    req_addr   = a;
    req_beats  = 16'(nb);
    req_vld    = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_rdy && k < 3000);
    if (!req_rdy) fail("req_accept_timeout");
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((aw_q.size() != 0 || push_q.size() != 0 || done_due) && k < 3000);
    if (k >= 3000) fail(tag);
  endtask

  initial begin
    int n;
    int p0;
    int d0;
    logic [31:0] sa;
    logic [7:0]  sl;
    logic [4:0]  si;

    repeat (2) @(negedge clk);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_awvalid", m_awvalid_o, 0);
    check("rst_atx_vld", atx_vld, 0);
    check("rst_wtx_vld", wtx_vld, 0);
    check("rst_req_done", req_done, 0);
    check("rst_awaddr", m_awaddr_o, 0);
    check("rst_awlen", m_awlen_o, 0);
    check("rst_awid", m_awid_o, 0);
    check("rst_awsize", m_awsize_o, 0);
    check("rst_awburst", m_awburst_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single aligned burst
    aw_log.delete();
    p0 = push_cnt;
    d0 = done_cnt;
    send_req(2'd2, 32'h1000, 16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_awvalid_o && n < 50);
    check("s1_latency", n, 2);
    wait_idle("s1_timeout");
    check("s1_aw_count", aw_log.size(), 1);
    if (aw_log.size() >= 1) begin
      check("s1_awaddr", aw_log[0].addr, 32'h1000);
      check("s1_awlen", aw_log[0].len, 8'd15);
      check("s1_awid", aw_log[0].id, 5'd17);
    end
    check("s1_pushes", push_cnt - p0, 1);
    check("s1_done", done_cnt - d0, 1);
    check("s1_done_chn", last_done_chn, 2'd2);

    // request near a 4 KB boundary
    aw_log.delete();
    send_req(2'd1, 32'h0FC0, 8);
    wait_idle("s2_timeout");
`ifdef ADMA_DM_AW_4KB_SPLIT_EN
    check("s2_aw_count", aw_log.size(), 2);
    if (aw_log.size() >= 2) begin
      check("s2_aw0_addr", aw_log[0].addr, 32'h0FC0);
      check("s2_aw0_len", aw_log[0].len, 8'd1);
      check("s2_aw1_addr", aw_log[1].addr, 32'h1000);
      check("s2_aw1_len", aw_log[1].len, 8'd5);
    end
`else
    check("s2_aw_count", aw_log.size(), 1);
    if (aw_log.size() >= 1) begin
      check("s2_aw0_addr", aw_log[0].addr, 32'h0FC0);
      check("s2_aw0_len", aw_log[0].len, 8'd7);
    end
`endif

    // multi-burst request
    aw_log.delete();
    d0 = done_cnt;
    send_req(2'd3, 32'h0, 300);
    wait_idle("s3_timeout");
`ifdef ADMA_DM_AW_4KB_SPLIT_EN
    check("s3_aw_count", aw_log.size(), 3);
    if (aw_log.size() >= 3) begin
      check("s3_aw0_addr", aw_log[0].addr, 32'h0);
      check("s3_aw0_len", aw_log[0].len, 8'd127);
      check("s3_aw1_addr", aw_log[1].addr, 32'h1000);
      check("s3_aw1_len", aw_log[1].len, 8'd127);
      check("s3_aw2_addr", aw_log[2].addr, 32'h2000);
      check("s3_aw2_len", aw_log[2].len, 8'd43);
    end
`else
    check("s3_aw_count", aw_log.size(), 2);
    if (aw_log.size() >= 2) begin
      check("s3_aw0_addr", aw_log[0].addr, 32'h0);
      check("s3_aw0_len", aw_log[0].len, 8'd255);
      check("s3_aw1_addr", aw_log[1].addr, 32'h2000);
      check("s3_aw1_len", aw_log[1].len, 8'd43);
    end
`endif
    check("s3_done", done_cnt - d0, 1);

    // back-pressure on the tracker push and on AW
    aw_log.delete();
    atx_rdy     = 1'b0;
    m_awready_i = 1'b0;
    send_req(2'd0, 32'h2000, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_no_atx", atx_vld, 0);
      check("s4_no_wtx", wtx_vld, 0);
      check("s4_no_aw", m_awvalid_o, 0);
    end
    @(posedge clk);
    #1;
    atx_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_awvalid_o && n < 50);
    sa = m_awaddr_o;
    sl = m_awlen_o;
    si = m_awid_o;
    check("s4_awaddr", sa, 32'h2000);
    check("s4_awlen", sl, 8'd3);
    check("s4_awid", si, 5'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s4_hold_valid", m_awvalid_o, 1);
      check("s4_hold_addr", m_awaddr_o, sa);
      check("s4_hold_len", m_awlen_o, sl);
      check("s4_hold_id", m_awid_o, si);
    end
    @(posedge clk);
    #1;
    m_awready_i = 1'b1;
    wait_idle("s4_timeout");
    check("s4_aw_count", aw_log.size(), 1);

    // zero-beat request
    aw_log.delete();
    p0 = push_cnt;
    send_req(2'd3, 32'h40, 0);
    @(negedge clk);
    check("s5_done", req_done, 1);
    check("s5_done_chn", req_done_chn_id, 2'd3);
    check("s5_rdy", req_rdy, 1);
    repeat (3) @(negedge clk);
    check("s5_no_aw", aw_log.size(), 0);
    check("s5_no_push", push_cnt - p0, 0);

    // randomized traffic against the model
    rand_mode = 1;
    for (int r = 0; r < 60; r++) begin
      logic [31:0] ra;
      int rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: ra = ra;
        1: ra = {ra[31:12], 12'hF00} + 32'($urandom_range(0, 255));
        2: ra = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
        default: ra = ra & 32'h0003_FFFF;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 700);
      send_req(2'($urandom_range(0, 3)), ra, rb);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_mode = 0;
    @(posedge clk);
    #2;
    atx_rdy     = 1'b1;
    wtx_rdy     = 1'b1;
    m_awready_i = 1'b1;
    wait_idle("rand_timeout");

    // reset while an AW is pending
    aw_log.delete();
    m_awready_i = 1'b0;
    send_req(2'd1, 32'h5000, 300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_awvalid_o && n < 50);
    check("s6_in_issue", m_awvalid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_awvalid_drop", m_awvalid_o, 0);
    check("s6_rdy_in_reset", req_rdy, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_awready_i = 1'b1;
    @(negedge clk);
    check("s6_rdy_after", req_rdy, 1);
    aw_log.delete();
    send_req(2'd1, 32'h3000, 4);
    wait_idle("s6_timeout");
    check("s6_aw_count", aw_log.size(), 1);
    if (aw_log.size() >= 1) begin
      check("s6_awaddr", aw_log[0].addr, 32'h3000);
      check("s6_awlen", aw_log[0].len, 8'd3);
      check("s6_awid", aw_log[0].id, 5'd9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/adma_dm_axi_aw.md
# adma_dm_axi_aw

AXI write-address issuer of the DMA data mover. It accepts one write request per transfer from the channel arbiter, given as channel, start address and beat count. It splits the request into AXI INCR bursts and issues them on the AW channel. For every burst it reserves a slot in the downstream B-response tracker (`atx_*` port) and the W-data stage (`wtx_*` port).

## Interface
Parameters:
- `DMA_CHN_NUM`, 4: number of DMA channels.
- `MST_ID_W`, 5: AXI ID width.
- `ADDR_W`, 32: AXI address width.
- `ATX_DST_DATA_W`, 256: destination data width. `BEAT_BYTES` = `ATX_DST_DATA_W`/8.
- `ATX_MAX_BURST`, 256: maximum beats per burst, legal range 1..256.
- `BEAT_CNT_W`, 16: width of the request beat count.
- `DMA_CHN_NUM_W`, derived: `$clog2(DMA_CHN_NUM)`, or 1 if `DMA_CHN_NUM` is 1.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_chn_id`  in  `DMA_CHN_NUM_W`  requesting channel.
- `req_addr`  in  `ADDR_W`  start address. Low log2(`BEAT_BYTES`) bits are forced to 0 on latch.
- `req_beats`  in  `BEAT_CNT_W`  total beats to write.
- `req_vld` in 1, `req_rdy` out 1: request handshake.
- `req_done`  out  1  one-cycle pulse when the last burst of a request has been accepted on AW.
- `req_done_chn_id`  out  `DMA_CHN_NUM_W`  channel that `req_done` refers to.
- `chn_awid`  in  `DMA_CHN_NUM*MST_ID_W`  per-channel AWID, packed; slice i is the ID for channel i.
- `atx_chn_id` out, `atx_awid` out, `atx_vld` out, `atx_rdy` in: B-tracker push.
- `wtx_chn_id` out `DMA_CHN_NUM_W`, `wtx_len` out 8, `wtx_vld` out, `wtx_rdy` in: W-stage push. `wtx_len` is AWLEN encoding.
- `m_awid_o`, `m_awaddr_o`, `m_awlen_o` (8), `m_awsize_o` (3), `m_awburst_o` (2), `m_awvalid_o` out; `m_awready_i` in: AXI AW channel.

## Operation
The block is a three-state FSM: IDLE, CALC, ISSUE.

**IDLE**
- `req_rdy` = 1.
- On `req_vld & req_rdy`, latch the channel, the aligned address and `req_beats` into `rem`.
- If `req_beats` = 0: issue no AW. Pulse `req_done` in the next cycle. Stay in IDLE.
- Otherwise go to CALC.

**CALC**
- `req_rdy` = 0.
- Compute the burst size:
  - `to4k` = (4096 − `addr[11:0]`)/`BEAT_BYTES`.
  - `beats` = min(`rem`, `to4k`, `ATX_MAX_BURST`).
- When `atx_rdy & wtx_rdy`:
  - Assert `atx_vld` and `wtx_vld` combinationally in the same cycle. `atx_awid` is the `chn_awid` slice for the channel. `wtx_len` = `beats` − 1.
  - Register the AW fields:
    - `awaddr` = `addr`.
    - `awlen` = `beats` − 1.
    - `awsize` = log2(`BEAT_BYTES`).
    - `awburst` = 2'b01.
    - `awid` = the channel slice of `chn_awid`.
  - Go to ISSUE.
- Otherwise stay in CALC. No pushes are made.

**ISSUE**
- `m_awvalid_o` = 1, with all AW fields held stable.
- On `m_awready_i`:
  - `addr` += `beats`·`BEAT_BYTES` (modulo 2^`ADDR_W`).
  - `rem` −= `beats`.
  - If `rem` becomes 0: go to IDLE and pulse `req_done` with the channel.
  - Otherwise go back to CALC.

**Other rules**
- B-tracker and W-stage slots are reserved before the AW handshake. The W stage may therefore emit data before AW, which AXI permits.
- Bursts never cross a 4 KB boundary.
- `rem` and the address arithmetic are unsigned, at `BEAT_CNT_W` and `ADDR_W` respectively. No overflow check is made on address wrap.

## Timing
- Reset values:
  - State = IDLE, `req_rdy` = 1.
  - `m_awvalid_o`, `atx_vld`, `wtx_vld`, `req_done` = 0.
  - All AW field registers = 0.
- Latency: request handshake at cycle T. Earliest `m_awvalid_o` is at T+2 (one cycle in CALC).
- Throughput: at most one burst per 2 cycles.
- `m_awvalid_o` never depends on `m_awready_i` and never drops before the handshake.
- `req_done` is registered and asserts in the cycle after the final AW handshake, or after acceptance of a zero-beat request.
- A new request can be accepted in the same cycle `req_done` is high.
- Reset mid-burst returns the FSM to IDLE asynchronously. `m_awvalid_o` drops immediately and partial requests are discarded.

## Configuration
- Macro: `ADMA_DM_AW_4KB_SPLIT_EN`.
- Defined: the `to4k` term is applied to the burst size as described above.
- Undefined: `beats` = min(`rem`, `ATX_MAX_BURST`). The caller guarantees that no request crosses a 4 KB boundary, and `to4k` logic is not synthesised.

## Test plan
All scenarios use `BEAT_BYTES` = 32 and the default parameters.

1. `req_addr` 0x1000, `req_beats` 16, chn 2 → one AW: `awaddr` 0x1000, `awlen` 15, `awsize` 5, `awburst` 01, `awid` = `chn_awid` slice 2. One push each on `atx`/`wtx` (`wtx_len` 15). One `req_done` pulse with chn 2.
2. With the macro defined: `req_addr` 0x0FC0, `req_beats` 8 → AW (0x0FC0, len 1), then AW (0x1000, len 5). Without the macro: a single AW (0x0FC0, len 7).
3. `req_addr` 0, `req_beats` 300 → AWs (0x0, len 127), (0x1000, len 127), (0x2000, len 43). `req_done` pulses once, after the third AW.
4. `atx_rdy` = 0 for 4 cycles → FSM stays in CALC with no `atx`/`wtx` push and no `m_awvalid_o`. Then `m_awready_i` = 0 for 5 cycles → `m_awvalid_o` and all AW fields stay stable.
5. `req_beats` 0 → no AW and no pushes. `req_done` pulses the next cycle and `req_rdy` stays 1.
6. `rst_n` asserted during ISSUE → `m_awvalid_o` goes to 0 immediately and `req_rdy` = 1 after release. The next request issues from its own start address.
